// File: rtl/ram_arbiter_if.sv
// Requester-side memory port: request/payload from the requester, grant and
// read response back from the arbiter.
interface ram_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SEL_WIDTH  = 4
);
   logic                  req;
   logic [SEL_WIDTH-1:0]  write_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, write_en, addr, write_data,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, write_en, addr, write_data,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read RAM.
// Optional RAM_ARBITER_ROUND_ROBIN_EN: alternate grants when both ports request.
module ram_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned SEL_WIDTH    = 4,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_arbiter_if.slave          m0,
   ram_arbiter_if.slave          m1,
   output logic                  ram_en,
   output logic [SEL_WIDTH-1:0]  ram_write_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   input  logic [DATA_WIDTH-1:0] ram_read_data
);

   localparam int unsigned CNT_WIDTH = 4;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] STARVE_LIM = CNT_WIDTH'(STARVE_LIMIT);

   logic [CNT_WIDTH-1:0] starve_cnt;
   logic                 resp_valid;
   logic                 resp_owner;
   logic                 gnt0;
   logic                 gnt1;
   logic                 force1;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
   logic                 last_gnt;
`endif

   // Grant selection; nothing is granted while reset is held
   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      force1 = m1.req && (starve_cnt >= STARVE_LIM);
      if (rst) begin
         if (force1) begin
            gnt1 = 1'b1;
         end else if (m0.req && m1.req) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
`else
            gnt0 = 1'b1;
`endif
         end else if (m0.req) begin
            gnt0 = 1'b1;
         end else if (m1.req) begin
            gnt1 = 1'b1;
         end
      end
   end

   // RAM request mux from the granted port
   always_comb begin
      ram_en         = 1'b0;
      ram_write_en   = '0;
      ram_addr       = '0;
      ram_write_data = '0;
      if (gnt0) begin
         ram_en         = 1'b1;
         ram_write_en   = m0.write_en;
         ram_addr       = m0.addr;
         ram_write_data = m0.write_data;
      end else if (gnt1) begin
         ram_en         = 1'b1;
         ram_write_en   = m1.write_en;
         ram_addr       = m1.addr;
         ram_write_data = m1.write_data;
      end
   end

   // Response tracking and fetch starvation counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_valid <= 1'b0;
         resp_owner <= 1'b0;
         starve_cnt <= '0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
         last_gnt   <= 1'b0;
`endif
      end else begin
         resp_valid <= gnt0 || gnt1;
         resp_owner <= gnt1;
         if (!m1.req || gnt1) begin
            starve_cnt <= '0;
         end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_WIDTH'(1);
         end
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
         if (gnt0 || gnt1) begin
            last_gnt <= gnt1;
         end
`endif
      end
   end

   assign m0.gnt    = gnt0;
   assign m1.gnt    = gnt1;
   assign m0.rvalid = resp_valid && !resp_owner;
   assign m1.rvalid = resp_valid && resp_owner;
   assign m0.rdata  = (resp_valid && !resp_owner) ? ram_read_data : '0;
   assign m1.rdata  = (resp_valid && resp_owner) ? ram_read_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural byte-lane RAM attached.
module tb_ram_arbiter;

   localparam int unsigned STARVE_LIMIT = 4;

   typedef struct packed {
      logic        valid;
      logic        port;
      logic [31:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ram_en;
   logic [3:0]  ram_write_en;
   logic [31:0] ram_addr;
   logic [31:0] ram_write_data;
   logic [31:0] ram_read_data = '0;

   ram_arbiter_if m0_if ();
   ram_arbiter_if m1_if ();

   ram_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
      .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
      .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: synchronous read, byte-lane write, returns 0 on writes
   logic [31:0] ram_mem [0:255];
   always @(posedge clk) begin
      if (ram_en) begin
         if (|ram_write_en) begin
            for (int b = 0; b < 4; b++)
               if (ram_write_en[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_write_data[8*b +: 8];
            ram_read_data <= '0;
         end else begin
            ram_read_data <= ram_mem[ram_addr[9:2]];
         end
      end
   end

   logic [31:0] shadow [0:255];
   resp_t       sb [$];
   int          checks = 0;
   int          errors = 0;
   int          m_starve = 0;
   logic        m_last = 1'b0;
   int          gnt_cnt = 0;
   int          rv_cnt = 0;
   int          m1_gnt_hits = 0;

   // One clock of stimulus: check the previous cycle's response, then this cycle's grant
   task automatic cycle(input logic r0, input logic [3:0] we0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic [3:0] we1, input logic [31:0] a1, input logic [31:0] d1,
                        input string tag);
      resp_t       exp;
      resp_t       nxt;
      logic        e0, e1, exp0v, exp1v;
      logic [31:0] ea, ed;
      logic [3:0]  ew;
      @(negedge clk);
      m0_if.req = r0; m0_if.write_en = we0; m0_if.addr = a0; m0_if.write_data = d0;
      m1_if.req = r1; m1_if.write_en = we1; m1_if.addr = a1; m1_if.write_data = d1;
      #1;
      exp = (sb.size() > 0) ? sb.pop_front() : resp_t'('0);
      exp0v = exp.valid && !exp.port;
      exp1v = exp.valid && exp.port;
      checks++; if (m0_if.rvalid !== exp0v) begin errors++; $display("FAIL %s m0_rvalid got %0b want %0b", tag, m0_if.rvalid, exp0v); end
      checks++; if (m1_if.rvalid !== exp1v) begin errors++; $display("FAIL %s m1_rvalid got %0b want %0b", tag, m1_if.rvalid, exp1v); end
      checks++; if (m0_if.rdata !== (exp0v ? exp.data : 32'h0)) begin errors++; $display("FAIL %s m0_rdata got %08h want %08h", tag, m0_if.rdata, exp0v ? exp.data : 32'h0); end
      checks++; if (m1_if.rdata !== (exp1v ? exp.data : 32'h0)) begin errors++; $display("FAIL %s m1_rdata got %08h want %08h", tag, m1_if.rdata, exp1v ? exp.data : 32'h0); end
      rv_cnt += int'(m0_if.rvalid) + int'(m1_if.rvalid);

      e0 = 1'b0; e1 = 1'b0;
      if (r1 && m_starve >= int'(STARVE_LIMIT)) e1 = 1'b1;
      else if (r0 && r1) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
         if (m_last) e0 = 1'b1; else e1 = 1'b1;
`else
         e0 = 1'b1;
`endif
      end
      else if (r0) e0 = 1'b1;
      else if (r1) e1 = 1'b1;
      ea = e0 ? a0 : (e1 ? a1 : 32'h0);
      ew = e0 ? we0 : (e1 ? we1 : 4'h0);
      ed = e0 ? d0 : (e1 ? d1 : 32'h0);
      checks++; if (m0_if.gnt !== e0) begin errors++; $display("FAIL %s m0_gnt got %0b want %0b", tag, m0_if.gnt, e0); end
      checks++; if (m1_if.gnt !== e1) begin errors++; $display("FAIL %s m1_gnt got %0b want %0b", tag, m1_if.gnt, e1); end
      checks++; if (ram_en !== (e0 | e1)) begin errors++; $display("FAIL %s ram_en got %0b want %0b", tag, ram_en, e0 | e1); end
      checks++; if (ram_addr !== ea || ram_write_en !== ew || ram_write_data !== ed) begin
         errors++; $display("FAIL %s ram_bus got %08h/%h/%08h want %08h/%h/%08h", tag, ram_addr, ram_write_en, ram_write_data, ea, ew, ed);
      end
      gnt_cnt += int'(m0_if.gnt) + int'(m1_if.gnt);
      m1_gnt_hits += int'(m1_if.gnt);

      nxt = '0;
      if (e0 || e1) begin
         nxt.valid = 1'b1;
         nxt.port  = e1;
         if (ew != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (ew[b]) shadow[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
            nxt.data = 32'h0;
         end else begin
            nxt.data = shadow[ea[9:2]];
         end
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
         m_last = e1;
`endif
      end
      sb.push_back(nxt);
      if (!r1 || e1) m_starve = 0;
      else if (m_starve < 15) m_starve++;
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, tag);
   endtask

   task automatic test_reset();
      m0_if.req = 1'b1; m0_if.write_en = 4'h0; m0_if.addr = 32'h40; m0_if.write_data = 32'h0;
      m1_if.req = 1'b1; m1_if.write_en = 4'h0; m1_if.addr = 32'h44; m1_if.write_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0) begin errors++; $display("FAIL reset gnt got %0b%0b want 00", m0_if.gnt, m1_if.gnt); end
      checks++; if (ram_en !== 1'b0 || ram_addr !== 32'h0 || ram_write_en !== 4'h0 || ram_write_data !== 32'h0) begin
         errors++; $display("FAIL reset ram_bus got en=%0b addr=%08h want all 0", ram_en, ram_addr);
      end
      checks++; if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0 || m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin
         errors++; $display("FAIL reset rsp got %0b%0b want 00", m0_if.rvalid, m1_if.rvalid);
      end
      @(negedge clk);
      m0_if.req = 1'b0; m1_if.req = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_read_after_write();
      cycle(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 32'h0, "raw_wr");
      cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0, "raw_rd");
      idle("raw_rsp");
   endtask

   task automatic test_partial_write();
      cycle(1'b1, 4'b0011, 32'h20, 32'h12345678, 1'b0, 4'h0, 32'h0, 32'h0, "pw_wr");
      idle("pw_ack");
      cycle(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "pw_rd");
      idle("pw_rsp");
      checks++; if (shadow[8] !== 32'h00005678) begin errors++; $display("FAIL pw_expect got %08h want 00005678", shadow[8]); end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 4'hF, 32'h30, 32'hA5A5_0001, 1'b0, 4'h0, 32'h0, 32'h0, "b2b_w0");
      cycle(1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "b2b_r0");
      cycle(1'b1, 4'b1100, 32'h30, 32'h5A5A_FFFF, 1'b0, 4'h0, 32'h0, 32'h0, "b2b_w1");
      cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h30, 32'h0, "b2b_r1");
      cycle(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "b2b_r2");
      idle("b2b_rsp");
   endtask

   task automatic test_starvation();
      m1_gnt_hits = 0;
      for (int i = 0; i < 15; i++)
         cycle(1'b1, 4'h0, 32'h20, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0, "starve");
      idle("starve_rsp");
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      checks++; if (m1_gnt_hits < 7 || m1_gnt_hits > 8) begin errors++; $display("FAIL rr_share got %0d want 7..8", m1_gnt_hits); end
`else
      checks++; if (m1_gnt_hits !== 3) begin errors++; $display("FAIL starve_share got %0d want 3", m1_gnt_hits); end
`endif
   endtask

   task automatic test_alternating();
      gnt_cnt = 0; rv_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "alt_m0");
         idle("alt_gap0");
         cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'(32 + i * 4), 32'h0, "alt_m1");
         idle("alt_gap1");
      end
      checks++; if (gnt_cnt !== 16 || rv_cnt !== 16) begin errors++; $display("FAIL alt_count got gnt=%0d rvalid=%0d want 16/16", gnt_cnt, rv_cnt); end
   endtask

   task automatic test_reset_mid();
      resp_t exp;
      cycle(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "rmid_rd");
      #1 rst = 1'b0;
      #1;
      sb.delete();
      m_starve = 0; m_last = 1'b0;
      checks++; if (m0_if.rvalid !== 1'b0 || m0_if.rdata !== 32'h0) begin errors++; $display("FAIL rmid_rvalid got %0b want 0", m0_if.rvalid); end
      checks++; if (m0_if.gnt !== 1'b0 || ram_en !== 1'b0 || ram_addr !== 32'h0) begin
         errors++; $display("FAIL rmid_ram got gnt=%0b en=%0b addr=%08h want 0", m0_if.gnt, ram_en, ram_addr);
      end
      @(posedge clk);
      @(negedge clk);
      m0_if.req = 1'b0;
      m1_if.req = 1'b1; m1_if.write_en = 4'h0; m1_if.addr = 32'h10; m1_if.write_data = 32'h0;
      rst = 1'b1;
      #1;
      checks++; if (m1_if.gnt !== 1'b1 || m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rmid_first got gnt1=%0b rv0=%0b want 1/0", m1_if.gnt, m0_if.rvalid); end
      exp.valid = 1'b1; exp.port = 1'b1; exp.data = shadow[4];
      sb.push_back(exp);
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      m_last = 1'b1;
`endif
      idle("rmid_rsp");
      idle("rmid_end");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 32'h0;
         shadow[i]  = 32'h0;
      end
      test_reset();
      test_read_after_write();
      test_partial_write();
      test_back_to_back();
      test_starvation();
      test_alternating();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port, synchronous-read data RAM between two requesters.
- Port 0 is the data-memory access port (load/store unit). Port 1 is the instruction-fetch port.
- Grants at most one access per cycle, drives the RAM request signals for that access, and routes the read data returned one cycle later back to the granted port.
- Sits between the CPU memory stages and the RAM; also counts consecutive denials of port 1 so fetch is never starved.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- SEL_WIDTH, 4, byte write-enable width; one bit per byte lane.
- STARVE_LIMIT, 4, consecutive cycles port 1 may be denied while requesting before it is force-granted. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  port 0 access request.
- m0_write_en  in  SEL_WIDTH  port 0 byte write enables; all zero means read.
- m0_addr  in  ADDR_WIDTH  port 0 byte address.
- m0_write_data  in  DATA_WIDTH  port 0 store data.
- m0_gnt  out  1  port 0 access accepted this cycle.
- m0_rvalid  out  1  port 0 response valid.
- m0_rdata  out  DATA_WIDTH  port 0 read data.
- m1_req, m1_write_en, m1_addr, m1_write_data, m1_gnt, m1_rvalid, m1_rdata: same as the port 0 signals, for port 1.
- ram_en  out  1  RAM enable.
- ram_write_en  out  SEL_WIDTH  RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_write_data  out  DATA_WIDTH  RAM store data.
- ram_read_data  in  DATA_WIDTH  RAM read data; valid one cycle after a read is enabled. The RAM returns 0 for cycles that carried a write.

Behaviour:
- Handshake:
  - A requester holds req, write_en, addr and write_data stable until it sees gnt high in the same cycle.
  - gnt is combinational from the req inputs and the arbiter state.
  - At most one gnt is high per cycle.
- Default grant (fixed priority): m0 when m0_req=1; otherwise m1 when m1_req=1.
- Starvation counter:
  - 4-bit counter `starve_cnt`.
  - Increments when m1_req=1 and m1_gnt=0; saturates at 15.
  - Clears whenever m1_gnt=1 or m1_req=0.
  - When starve_cnt >= STARVE_LIMIT and m1_req=1, m1 is granted that cycle even if m0_req=1, and m0 is denied.
- RAM drive:
  - In a granted cycle: ram_en=1, and ram_write_en, ram_addr, ram_write_data come from the granted port.
  - With no grant, all ram_* outputs are 0.
- Response pipeline:
  - Registers `resp_valid` and `resp_owner` capture the grant on each rising edge.
  - The cycle after a grant, the owner's rvalid=1 and its rdata=ram_read_data. The other port sees rvalid=0, rdata=0.
  - Writes also produce rvalid (write acknowledge), with rdata=0.
  - Latency from gnt to rvalid is exactly 1 cycle.
  - Back-to-back grants give one response per cycle, in grant order.
- Simultaneous events: a new grant and the response to the previous grant occur in the same cycle, with no bubble.
- Reset:
  - While rst=0: gnt=0 for both ports, all ram_* outputs=0, rvalid=0, rdata=0, starve_cnt=0, resp_valid=0, resp_owner=0, last_gnt=0.
  - Assertion mid-transfer discards the in-flight response; no rvalid is issued after reset release.
  - First grant is possible in the first cycle with rst=1.
- Width rules: no address translation is applied; the full address passes through. Byte-lane selection is the requester's job.

Optional Feature:
- Macro: RAM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - When both ports request, the grant goes to the port not granted last.
  - Register `last_gnt` (reset 0) updates on every grant.
  - The starvation counter is still maintained, but it can never reach STARVE_LIMIT >= 2.
- Undefined: fixed priority with starvation forcing, exactly as in Behaviour; last_gnt is not implemented.

Test Plan:
- m1 read at addr 0x10 after a prior write of 0xDEADBEEF, m0 idle -> m1_gnt=1 same cycle; next cycle m1_rvalid=1, m1_rdata=0xDEADBEEF, m0_rvalid=0.
- m0 write_en=4'b0011, data 0x12345678 at 0x20, then m0 read of 0x20 (prior content 0) -> read returns 0x00005678; write ack has m0_rvalid=1, m0_rdata=0.
- Both ports request continuously, fixed priority, STARVE_LIMIT=4 -> grant pattern m0,m0,m0,m0,m1 repeating; starve_cnt reaches 4 then clears.
- Same stimulus with RAM_ARBITER_ROUND_ROBIN_EN -> grants alternate m0,m1,m0,m1; responses alternate one cycle later.
- rst driven low the cycle after an m0 read grant -> m0_rvalid stays 0, all ram_* outputs 0 asynchronously; after release, a new m1 request is granted in the first cycle.
- Alternating single requests, each held for one cycle with a gap -> no lost or duplicated responses; the rvalid count equals the gnt count.
